inverter_loop_sequencer: RTL and testbench

Digital stimulus/measurement controller for the on-die analog double-inverter chain. It drives the chain input with a programmable burst of square-wave periods. It samples the chain output through a synchronizer, measures the per-edge propagation delay in clock cycles and flags missing responses. It sits in the digital half of the tile between the user I/O pins and the analog pin pair, so the analog cell can be characterised without external instruments.

---
 rtl/inverter_loop_sequencer_if.sv | 21 ++
 rtl/inverter_loop_sequencer.sv | 87 ++++++++
 tb/tb_inverter_loop_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/inverter_loop_sequencer_if.sv
// inverter_loop_sequencer_if: control/status bundle between the user side and the sequencer
interface inverter_loop_sequencer_if #(parameter int CNT_W = 8);
  logic ena;
  logic start;
  logic [7:0] n_pulses;
  logic busy;
  logic done;
  logic err;
  logic [8:0] edge_count;
  logic [CNT_W-1:0] delay_last;
  logic [CNT_W-1:0] delay_max;
  logic [CNT_W-1:0] delay_min;
  modport master (
    output ena, start, n_pulses,
    input  busy, done, err, edge_count, delay_last, delay_max, delay_min
  );
  modport slave (
    input  ena, start, n_pulses,
    output busy, done, err, edge_count, delay_last, delay_max, delay_min
  );
endinterface

// File: rtl/inverter_loop_sequencer.sv
// inverter_loop_sequencer: square-wave burst driver and edge-delay meter for the analog inverter chain
// INVSEQ_MIN_TRACK_EN enables burst-minimum delay tracking; otherwise delay_min reads all-ones
module inverter_loop_sequencer #(
  parameter int HALF_PERIOD = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  inverter_loop_sequencer_if.slave ctl,
  input  logic resp_in,
  output logic stim_out
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, FINISH} state_t;
  localparam logic [CNT_W-1:0] PH_END = CNT_W'(HALF_PERIOD - 1);
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] ph, delay_last, delay_max;
  logic [7:0] n_lat;
  logic [8:0] edge_count, edge_next;
  logic err, accept, tog, rec, set_err, match, ph_end, burst_end;
  assign match = sync[SYNC_STAGES-1] == stim_out;
  assign ph_end = ph == PH_END;
  assign rec = state == WAIT && match;
  assign edge_next = edge_count + 9'(rec);
  // a match on the last WAIT cycle already counts toward the burst total
  assign burst_end = edge_next == {n_lat, 1'b0};
  always_comb begin
    state_nx = state;
    accept = 1'b0;
    tog = 1'b0;
    set_err = 1'b0;
    case (state)
      IDLE: begin
        accept = ctl.start;
        tog = ctl.start && ctl.n_pulses != 8'd0;
        state_nx = !ctl.start ? IDLE : tog ? WAIT : FINISH;
      end
      WAIT, HOLD: begin
        set_err = state == WAIT && !match && ph_end;
        tog = ph_end && !set_err && !burst_end;
        state_nx = !ph_end ? (rec ? HOLD : state) : (set_err || burst_end) ? FINISH : WAIT;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else if (ctl.ena) state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      stim_out <= 1'b0;
      ph <= '0;
      n_lat <= '0;
      edge_count <= '0;
      delay_last <= '0;
      delay_max <= '0;
      err <= 1'b0;
    end else if (ctl.ena) begin
      sync <= {sync[SYNC_STAGES-2:0], resp_in};
      stim_out <= stim_out ^ tog;
      ph <= (accept || tog) ? '0 : (state == WAIT || state == HOLD) ? ph + CNT_W'(1) : ph;
      n_lat <= accept ? ctl.n_pulses : n_lat;
      edge_count <= accept ? '0 : edge_next;
      delay_last <= accept ? '0 : rec ? ph : delay_last;
      delay_max <= accept ? '0 : (rec && ph > delay_max) ? ph : delay_max;
      err <= accept ? 1'b0 : err | set_err;
    end
  end
`ifdef INVSEQ_MIN_TRACK_EN
  logic [CNT_W-1:0] delay_min;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) delay_min <= '1;
    else if (ctl.ena) delay_min <= accept ? '1 : (rec && ph < delay_min) ? ph : delay_min;
  assign ctl.delay_min = delay_min;
`else
  assign ctl.delay_min = '1;
`endif
  // done is qualified by ena so a frozen FINISH still yields a single enabled-cycle pulse
  assign ctl.busy = state != IDLE;
  assign ctl.done = state == FINISH && ctl.ena;
  assign ctl.err = err;
  assign ctl.edge_count = edge_count;
  assign ctl.delay_last = delay_last;
  assign ctl.delay_max = delay_max;
endmodule

// File: tb/tb_inverter_loop_sequencer.sv
// tb_inverter_loop_sequencer: random bursts through a modelled chain delay line, checked against closed-form expectations
module tb_inverter_loop_sequencer;
  localparam int HP = 16, SS = 2, CW = 8;
`ifdef INVSEQ_MIN_TRACK_EN
  localparam bit MIN_EN = 1'b1;
`else
  localparam bit MIN_EN = 1'b0;
`endif
  typedef struct packed {
    logic [8:0] ec;
    logic err;
    logic [7:0] last, mx, mn;
    logic [15:0] lat;
    logic [3:0] dones;
    logic stim_e0, stim_end, hung;
  } res_t;
  logic clk = 1'b0, rst_n = 1'b0, resp_in = 1'b0;
  logic stim_out;
  int errors = 0, checks = 0;
  logic [63:0] hist = '0;
  int dly = 0;
  bit tied = 1'b0, ena_rand = 1'b0;
  inverter_loop_sequencer_if #(.CNT_W(CW)) ctl();
  inverter_loop_sequencer #(.HALF_PERIOD(HP), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ctl(ctl), .resp_in(resp_in), .stim_out(stim_out)
  );
  always #5 clk = ~clk;
  // chain model: resp_in follows stim_out after dly enabled cycles; ena re-drawn each negedge
  always @(negedge clk) begin
    if (ctl.ena) hist = {hist[62:0], stim_out};
    resp_in = tied ? 1'b0 : hist[dly];
    ctl.ena = ena_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic res_t model(input int n, input bit t, input int d_line, input logic prev);
    res_t r;
    int d = d_line + SS;
    r = '0;
    r.mn = 8'hff;
    r.dones = 4'd1;
    r.stim_e0 = prev;
    r.stim_end = prev;
    if (n == 0) return r;
    r.stim_e0 = ~prev;
    if (t || d > HP - 1) begin
      r.err = 1'b1;
      r.lat = 16'(HP);
      r.stim_end = ~prev;
      return r;
    end
    r.ec = 9'(2 * n);
    r.last = 8'(d);
    r.mx = 8'(d);
    r.mn = MIN_EN ? 8'(d) : 8'hff;
    r.lat = 16'(2 * n * HP);
    return r;
  endfunction

  task automatic idle(input int k);
    repeat (k) begin @(negedge clk); #1; end
  endtask

  task automatic run_burst(input int n, input bit hold, output res_t o);
    int lat = 0;
    o = '0;
    o.hung = 1'b1;
    ctl.start = 1'b1;
    ctl.n_pulses = 8'(n);
    for (int k = 0; k < 100 && !ctl.ena; k++) begin @(negedge clk); #1; end
    @(negedge clk); #1;
    o.stim_e0 = stim_out;
    if (!hold) ctl.start = 1'b0;
    ctl.n_pulses = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if (ctl.done) begin o.dones = o.dones + 4'd1; o.lat = 16'(lat); end
      if (!ctl.busy) begin o.hung = 1'b0; break; end
      if (ctl.ena) lat++;
      @(negedge clk); #1;
    end
    o.ec = ctl.edge_count;
    o.err = ctl.err;
    o.last = ctl.delay_last;
    o.mx = ctl.delay_max;
    o.mn = ctl.delay_min;
    o.stim_end = stim_out;
  endtask

  task automatic test_reset();
    idle(3);
    checks++;
    if ({stim_out, ctl.busy, ctl.done, ctl.err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {stim_out, ctl.busy, ctl.done, ctl.err});
    end
    checks++;
    if ({ctl.edge_count, ctl.delay_last, ctl.delay_max, ctl.delay_min} !== {9'd0, 8'd0, 8'd0, 8'hff}) begin
      errors++; $display("FAIL reset_results got %h want %h", {ctl.edge_count, ctl.delay_last, ctl.delay_max, ctl.delay_min}, {9'd0, 8'd0, 8'd0, 8'hff});
    end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_loopback();
    res_t o, e;
    dly = 0;
    idle(20);
    e = model(3, 1'b0, 0, stim_out);
    run_burst(3, 1'b0, o);
    checks++; if (o.ec !== e.ec) begin errors++; $display("FAIL loop_edge_count got %0d want %0d", o.ec, e.ec); end
    checks++; if (o.last !== e.last) begin errors++; $display("FAIL loop_delay_last got %0d want %0d", o.last, e.last); end
    checks++; if (o.mx !== e.mx) begin errors++; $display("FAIL loop_delay_max got %0d want %0d", o.mx, e.mx); end
    checks++; if (o.mn !== e.mn) begin errors++; $display("FAIL loop_delay_min got %0d want %0d", o.mn, e.mn); end
    checks++; if (o.err !== e.err) begin errors++; $display("FAIL loop_err got %b want %b", o.err, e.err); end
    checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL loop_latency got %0d want %0d", o.lat, e.lat); end
    checks++; if (o.dones !== e.dones) begin errors++; $display("FAIL loop_done_pulses got %0d want %0d", o.dones, e.dones); end
    checks++; if ({o.stim_e0, o.stim_end, o.hung} !== {e.stim_e0, e.stim_end, e.hung}) begin
      errors++; $display("FAIL loop_stim got %b want %b", {o.stim_e0, o.stim_end, o.hung}, {e.stim_e0, e.stim_end, e.hung});
    end
  endtask

  task automatic test_delay();
    res_t o, e;
    dly = 5;
    idle(40);
    e = model(1, 1'b0, 5, stim_out);
    run_burst(1, 1'b0, o);
    checks++; if (o.mx !== 8'd7) begin errors++; $display("FAIL delay5_max got %0d want 7", o.mx); end
    checks++; if (o !== e) begin errors++; $display("FAIL delay5_all got %h want %h", o, e); end
  endtask

  task automatic test_timeout();
    res_t o, e;
    dly = 0;
    idle(40);
    tied = 1'b1;
    idle(4);
    e = model(2, 1'b1, 0, stim_out);
    run_burst(2, 1'b0, o);
    checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", o.err); end
    checks++; if (o !== e) begin errors++; $display("FAIL timeout_all got %h want %h", o, e); end
    tied = 1'b0;
    idle(40);
  endtask

  task automatic test_zero();
    res_t o, e;
    e = model(0, 1'b0, 0, stim_out);
    run_burst(0, 1'b0, o);
    checks++; if (o !== e) begin errors++; $display("FAIL zero_pulses got %h want %h", o, e); end
  endtask

  task automatic test_boundary();
    res_t o, e;
    dly = HP - SS - 1;
    idle(40);
    e = model(2, 1'b0, dly, stim_out);
    run_burst(2, 1'b0, o);
    checks++; if (o !== e) begin errors++; $display("FAIL edge_last_cycle got %h want %h", o, e); end
    dly = HP - SS;
    idle(40);
    e = model(1, 1'b0, dly, stim_out);
    run_burst(1, 1'b0, o);
    checks++; if (o !== e) begin errors++; $display("FAIL edge_one_late got %h want %h", o, e); end
  endtask

  task automatic test_midburst_reset();
    res_t o, e;
    dly = 0;
    idle(40);
    ctl.start = 1'b1;
    ctl.n_pulses = 8'd3;
    for (int i = 0; i < 500 && ctl.edge_count != 9'd3; i++) begin @(negedge clk); #1; end
    ctl.start = 1'b0;
    checks++; if (ctl.edge_count !== 9'd3) begin errors++; $display("FAIL midrst_reach got %0d want 3", ctl.edge_count); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stim_out, ctl.busy, ctl.done, ctl.err, ctl.edge_count, ctl.delay_last, ctl.delay_max, ctl.delay_min} !== {4'b0000, 9'd0, 8'd0, 8'd0, 8'hff}) begin
      errors++; $display("FAIL midrst_outputs got %h want %h", {stim_out, ctl.busy, ctl.done, ctl.err, ctl.edge_count, ctl.delay_last, ctl.delay_max, ctl.delay_min}, {4'b0000, 9'd0, 8'd0, 8'd0, 8'hff});
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(40);
    e = model(3, 1'b0, 0, stim_out);
    run_burst(3, 1'b0, o);
    checks++; if (o !== e) begin errors++; $display("FAIL midrst_rerun got %h want %h", o, e); end
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    ena_rand = 1'b1;
    dly = $urandom_range(0, HP - SS - 1);
    idle(60);
    e = model(2, 1'b0, dly, stim_out);
    run_burst(2, 1'b1, o);
    checks++; if (o !== e) begin errors++; $display("FAIL b2b_first got %h want %h", o, e); end
    e = model(3, 1'b0, dly, stim_out);
    run_burst(3, 1'b0, o);
    checks++; if (o !== e) begin errors++; $display("FAIL b2b_second got %h want %h", o, e); end
    idle(10);
    checks++; if (ctl.busy !== 1'b0) begin errors++; $display("FAIL b2b_stays_idle got %b want 0", ctl.busy); end
    ena_rand = 1'b0;
  endtask

  task automatic test_random();
    res_t o, e;
    int n;
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(0, 4);
      dly = $urandom_range(0, HP - SS);
      ena_rand = 1'($urandom_range(0, 1));
      idle(60);
      e = model(n, 1'b0, dly, stim_out);
      run_burst(n, 1'b0, o);
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL random_%0d n=%0d dly=%0d got %h want %h", it, n, dly, o, e);
      end
    end
    ena_rand = 1'b0;
  endtask

  initial begin
    ctl.ena = 1'b1;
    ctl.start = 1'b0;
    ctl.n_pulses = 8'd0;
    test_reset();
    test_loopback();
    test_delay();
    test_timeout();
    test_zero();
    test_boundary();
    test_midburst_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
